// File: rtl/uart_fb_loader_pkg.sv
// Shared constants for the UART-to-framebuffer loader: protocol bytes, framebuffer geometry,
// pixel field widths and FSM state encodings.
package uart_fb_loader_pkg;

  localparam int unsigned ADDR_W_DEF   = 15;
  localparam int unsigned FB_DEPTH_DEF = 19200;
  localparam int unsigned TIMEOUT_DEF  = 500000;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  localparam int unsigned PIX_R_W = 5;
  localparam int unsigned PIX_G_W = 5;
  localparam int unsigned PIX_B_W = 5;
  localparam int unsigned PIX_W   = PIX_R_W + PIX_G_W + PIX_B_W;

  typedef logic [2:0] fb_state_t;

  localparam fb_state_t ST_IDLE = 3'd0;
  localparam fb_state_t ST_A_HI = 3'd1;
  localparam fb_state_t ST_A_LO = 3'd2;
  localparam fb_state_t ST_P_HI = 3'd3;
  localparam fb_state_t ST_P_LO = 3'd4;

  // Bit 15 of the received pixel word is dropped before the high byte is stored.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [PIX_W-9:0] hi,
                                                  input logic [7:0]       lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_fb_loader_if.sv
// Loader-side bundle: UART RX/TX handshake plus the framebuffer write port.
interface uart_fb_loader_if
  import uart_fb_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_busy;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              frame_err;

  modport master (
    output rx_valid, rx_data, tx_busy,
    input  tx_send, tx_data, wr_en, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  rx_valid, rx_data, tx_busy,
    output tx_send, tx_data, wr_en, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/uart_fb_loader_byte_timeout.sv
// Inter-byte timer: clears on each byte, counts while enabled, saturates at TIMEOUT-1.
module uart_fb_loader_byte_timeout #(
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (clear) begin
      timer_q <= '0;
    end else if (enable && (timer_q != LAST)) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign expired = (timer_q == LAST);

endmodule

// File: rtl/uart_fb_loader.sv
// Parses SYNC/ADDR_HI/ADDR_LO/PIX_HI/PIX_LO frames from the UART RX stream into framebuffer
// writes, answering each complete frame with ACK or NAK and dropping stalled partial frames.
module uart_fb_loader
  import uart_fb_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned FB_DEPTH  = FB_DEPTH_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE  = NAK_BYTE_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_fb_loader_if.slave  bus
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(FB_DEPTH);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-9:0] addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [PIX_W-9:0]  pix_hi_q, pix_hi_d;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;
  logic              reply_pending_q, reply_pending_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              expired;
  logic              timeout_abort;
  logic              tx_send;
  logic              queue_reply;
  logic [7:0]        reply_byte;
  logic [ADDR_W-1:0] addr_new;

  uart_fb_loader_byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_byte_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.rx_valid),
    .enable  (state_q != ST_IDLE),
    .expired (expired)
  );

  // A byte arriving in the expiry cycle takes priority over the abort.
  assign timeout_abort = expired && !bus.rx_valid && (state_q != ST_IDLE);
  assign addr_new      = {addr_hi_q, bus.rx_data};

  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    oor_d       = oor_q;
    pix_hi_d    = pix_hi_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    queue_reply = 1'b0;
    reply_byte  = ACK_BYTE;

    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) state_d = ST_A_HI;
        end
        ST_A_HI: begin
          addr_hi_d = bus.rx_data[ADDR_W-9:0];
          state_d   = ST_A_LO;
        end
        ST_A_LO: begin
          addr_d  = addr_new;
          oor_d   = ({1'b0, addr_new} >= DEPTH_W);
          state_d = ST_P_HI;
        end
        ST_P_HI: begin
          pix_hi_d = bus.rx_data[PIX_W-9:0];
          state_d  = ST_P_LO;
        end
        ST_P_LO: begin
          state_d     = ST_IDLE;
          queue_reply = 1'b1;
          if (oor_q) begin
            frame_err_d = 1'b1;
            reply_byte  = NAK_BYTE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pack_pixel(pix_hi_q, bus.rx_data);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_abort) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // A newer reply overwrites a still-pending one, so at most one byte goes out.
  assign tx_send         = reply_pending_q && !bus.tx_busy;
  assign reply_pending_d = queue_reply || (reply_pending_q && !tx_send);
  assign tx_data_d       = queue_reply ? reply_byte : tx_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_hi_q       <= '0;
      addr_q          <= '0;
      oor_q           <= 1'b0;
      pix_hi_q        <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      frame_err_q     <= 1'b0;
      reply_pending_q <= 1'b0;
      tx_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      addr_hi_q       <= addr_hi_d;
      addr_q          <= addr_d;
      oor_q           <= oor_d;
      pix_hi_q        <= pix_hi_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      frame_err_q     <= frame_err_d;
      reply_pending_q <= reply_pending_d;
      tx_data_q       <= tx_data_d;
    end
  end

  assign bus.tx_send   = tx_send;
  assign bus.tx_data   = tx_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_fb_loader.sv
// Bench for uart_fb_loader: directed frames plus randomized byte streams, compared each cycle
// against a frame-level model that collects bytes into a queue.
module tb_uart_fb_loader;
  import uart_fb_loader_pkg::*;

  localparam int unsigned TO    = 40;
  localparam int unsigned DEPTH = 19200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_fb_loader_if #(.ADDR_W(15)) bus ();

  uart_fb_loader #(
    .ADDR_W    (15),
    .FB_DEPTH  (DEPTH),
    .SYNC_BYTE (8'hA5),
    .ACK_BYTE  (8'h06),
    .NAK_BYTE  (8'h15),
    .TIMEOUT   (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  fq[$];
  int          silent;
  bit          m_wr, m_err, m_pending;
  logic [7:0]  m_tx;
  logic [14:0] m_addr, m_data;
  bit          busy_rand;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    silent    = 0;
    m_wr      = 1'b0;
    m_err     = 1'b0;
    m_pending = 1'b0;
    m_tx      = 8'h00;
    m_addr    = '0;
    m_data    = '0;
  endtask

  task automatic model_edge();
    bit          sent;
    logic [15:0] a, p;
    sent  = m_pending && !bus.tx_busy;
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (sent) m_pending = 1'b0;
    if (bus.rx_valid) begin
      silent = 0;
      if (fq.size() != 0 || bus.rx_data == 8'hA5) fq.push_back(bus.rx_data);
      if (fq.size() == 5) begin
        a = {fq[1], fq[2]} & 16'h7FFF;
        p = {fq[3], fq[4]} & 16'h7FFF;
        if (int'(a) < int'(DEPTH)) begin
          m_wr   = 1'b1;
          m_addr = a[14:0];
          m_data = p[14:0];
          m_tx   = 8'h06;
        end else begin
          m_err = 1'b1;
          m_tx  = 8'h15;
        end
        m_pending = 1'b1;
        fq.delete();
      end
    end else if (fq.size() != 0) begin
      silent++;
      if (silent == int'(TO)) begin
        fq.delete();
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("wr_en", 32'(bus.wr_en), 32'(m_wr));
    check_val("frame_err", 32'(bus.frame_err), 32'(m_err));
    check_val("tx_send", 32'(bus.tx_send), 32'(m_pending && !bus.tx_busy));
    check_val("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
    check_val("wr_data", 32'(bus.wr_data), 32'(m_data));
    check_val("tx_data", 32'(bus.tx_data), 32'(m_tx));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (busy_rand) bus.tx_busy = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    idle(gap);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] p, input int gap);
    send(8'hA5, gap);
    send(a[15:8], gap);
    send(a[7:0], gap);
    send(p[15:8], gap);
    send(p[7:0], gap);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;
    busy_rand    = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    send_frame(16'h0010, 16'h7C1F, 0);               // ACK write
    idle(3);
    send_frame(16'h4B00, 16'h1234, 0);               // first out-of-range address
    idle(3);
    send_frame(16'h4AFF, 16'h0ABC, 1);               // last in-range address
    idle(3);
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, TO + 5);  // timeout abort
    send_frame(16'h0002, 16'h0001, 0);
    idle(3);
    send(8'h00, 0); send(8'hFF, 0);                  // garbage before sync
    send_frame(16'h0003, 16'h8005, 0);
    idle(3);
    send_frame(16'h0123, 16'h4567, TO - 1);          // longest surviving gap
    idle(3);
    send(8'hA5, 0); send(8'h01, TO);                 // shortest aborting gap
    idle(3);

    bus.tx_busy = 1'b1;                              // reply held off by busy transmitter
    send_frame(16'h0044, 16'h2222, 0);
    idle(95);
    bus.tx_busy = 1'b0;
    idle(5);

    send_frame(16'h0005, 16'h1111, 0);               // back-to-back, then reset mid-frame
    send_frame(16'h0006, 16'hA5A5, 0);
    send(8'hA5, 0); send(8'h00, 0);
    do_reset();
    idle(3);

    busy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        send(8'($urandom), int'($urandom_range(0, 2)));
      end else if (kind == 1) begin
        send(8'hA5, 0);
        send(8'($urandom), int'($urandom_range(TO - 1, TO + 1)));
      end else begin
        logic [7:0] fb [5];
        fb[0] = 8'hA5;
        for (int j = 1; j < 5; j++) fb[j] = 8'($urandom);
        if (kind == 2) fb[1] = 8'($urandom_range(8'h4A, 8'h4B));
        for (int j = 0; j < 5; j++) send(fb[j], int'($urandom_range(0, 2)));
      end
    end
    busy_rand   = 1'b0;
    bus.tx_busy = 1'b0;
    idle(TO + 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
